// File: rtl/shift_sequencer.sv
// Multicycle shift unit: captures operand/amount/op on start and shifts one bit per clock.
// The final value lands in a result register that the control FSM reads later.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; result holds the last value
// SHIFT | one bit position per clock, cnt counts remaining steps
// DONE  | result newly valid for one cycle; start is accepted here
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNTW-1:0]  shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       opq_q, opq_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    // Single-position shift of the working register under the latched op.
    always_comb begin
        shifted = sreg_q;
        case (opq_q)
            OP_SLL:  shifted = {sreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, sreg_q[WIDTH-1:1]};
            OP_SRA:  shifted = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
            OP_ROR:  shifted = {sreg_q[0], sreg_q[WIDTH-1:1]};
            default: shifted = sreg_q;
        endcase
    end

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // State register (all flops, synchronous active-low reset).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            opq_q    <= OP_SLL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            opq_q    <= opq_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        opq_d    = opq_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    sreg_d = data_in;
                    cnt_d  = shamt;
                    opq_d  = op;
                    if (shamt == CNT_ZERO) begin
                        result_d = data_in;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt_q - CNT_ONE;
                // Last step: publish the once-more-shifted value directly.
                if (cnt_q == CNT_ONE) begin
                    result_d = shifted;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy   = (state_q == ST_SHIFT);
        done   = (state_q == ST_DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with hand-computed expectations.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] prev_result = 32'h0;

    shift_sequencer #(.WIDTH(32), .CNTW(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one operation and follow it to its DONE cycle; returns with the bench at DONE.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                         input logic [4:0] s, input logic [31:0] exp);
        int bc;
        op = o; data_in = d; shamt = s; start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs: they must have no effect while shifting.
        op = ~o; data_in = 32'hDEAD_BEEF; shamt = 5'h1F;
        bc = 0;
        while (!done && bc < 40) begin
            chk({tag, " busy"}, {31'b0, busy}, 32'd1);
            chk({tag, " result hold"}, result, prev_result);
            bc++;
            tick();
        end
        chk({tag, " latency"}, bc, {27'b0, s});
        chk({tag, " done"}, {31'b0, done}, 32'd1);
        chk({tag, " busy at done"}, {31'b0, busy}, 32'd0);
        chk({tag, " result"}, result, exp);
        prev_result = exp;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; data_in = 32'h0; shamt = 5'h0;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst result", result, 32'h0);
            chk("rst busy", {31'b0, busy}, 32'd0);
            chk("rst done", {31'b0, done}, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("idle result", result, 32'h0);
            chk("idle done", {31'b0, done}, 32'd0);
        end

        do_op("sra4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
        tick();
        chk("sra4 done pulse", {31'b0, done}, 32'd0);
        chk("sra4 idle hold", result, 32'hF800_0000);
        tick();

        do_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        tick();

        do_op("sll0", 2'b00, 32'h0000_0001, 5'd0, 32'h0000_0001);
        do_op("ror4 b2b", 2'b11, 32'h0000_000F, 5'd4, 32'hF000_0000);
        tick();
        chk("b2b done pulse", {31'b0, done}, 32'd0);
        chk("b2b idle busy", {31'b0, busy}, 32'd0);

        do_op("ror1", 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);
        tick();
        do_op("sll31", 2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000);
        tick();
        do_op("sra_pos", 2'b10, 32'h7000_0000, 5'd5, 32'h0380_0000);
        tick();

        // Start during SHIFT must be ignored.
        op = 2'b00; data_in = 32'h0000_0003; shamt = 5'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        data_in = 32'hFFFF_FFFF; shamt = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign busy", {31'b0, busy}, 32'd1);
        chk("ign hold", result, prev_result);
        tick();
        chk("ign done", {31'b0, done}, 32'd1);
        chk("ign result", result, 32'h0000_0018);
        prev_result = 32'h0000_0018;
        tick();
        chk("ign idle", {31'b0, done}, 32'd0);

        // Reset mid-operation.
        op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mid rst busy", {31'b0, busy}, 32'd0);
        chk("mid rst done", {31'b0, done}, 32'd0);
        chk("mid rst result", result, 32'h0);
        reset = 1'b1;
        prev_result = 32'h0;
        begin
            int seen_done = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (done || busy) seen_done++;
            end
            chk("mid no done", seen_done, 32'd0);
        end
        chk("mid hold", result, 32'h0);
        do_op("fresh sll10", 2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400);
        tick();
        chk("fresh idle", {31'b0, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
